line_arb: RTL and testbench

LINE_ARB -- requirements
Module: line_arb

---
 rtl/line_arb.sv | 141 ++++++++++++++
 tb/tb_line_arb.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_arb.sv
// Cache-line arbiter: picks one of NCH clients, latches its request for the qspi
// controller, and reports completion (done) or watchdog abort (err) back to it.
module line_arb #(
   parameter  int NCH         = 2,
   parameter  int PA          = 22,
   parameter  int LINE_LENGTH = 4,
   parameter  int FIXED_PRIO  = 0,
   parameter  int TIMEOUT     = 255,
   localparam int TW          = PA - $clog2(LINE_LENGTH),
   localparam int CHW         = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NCH-1:0]    req,
   input  logic [NCH-1:0]    write,
   input  logic [NCH-1:0]    mem,
   input  logic [NCH*TW-1:0] tag,
   output logic [NCH-1:0]    gnt,
   output logic [NCH-1:0]    done,
   output logic [NCH-1:0]    err,
   output logic              q_req,
   output logic              q_write,
   output logic              q_mem,
   output logic [TW-1:0]     q_tag,
   output logic [CHW-1:0]    q_chan,
   input  logic              q_done
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

   state_t          state_reg, state_next;
   logic [CHW-1:0]  ptr_reg;
   logic [CHW-1:0]  ptr_next;
   logic [CW-1:0]   cnt_reg;
   logic [CHW-1:0]  win;
   logic [CHW-1:0]  idx;
   logic            found;
   logic            start, finish_ok, expire;
   logic [TW-1:0]   tag_arr [NCH];

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_tag
         assign tag_arr[gi] = tag[gi*TW +: TW];
      end
   endgenerate

   // Search starts at ptr (round-robin) or at 0 (fixed priority), wrapping at NCH.
   always_comb begin
      win   = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         idx = CHW'((FIXED_PRIO != 0) ? i : ((int'(ptr_reg) + i) % NCH));
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign ptr_next = (q_chan == CHW'(NCH - 1)) ? '0 : q_chan + CHW'(1);
   assign q_req    = (state_reg == BUSY);

   always_comb begin
      state_next = state_reg;
      start      = 1'b0;
      finish_ok  = 1'b0;
      expire     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (|req) begin
               start      = 1'b1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            // q_done takes precedence over a coincident timeout.
            if (q_done) begin
               finish_ok  = 1'b1;
               state_next = GAP;
            end else if (TIMEOUT != 0 && cnt_reg == CW'(TIMEOUT - 1)) begin
               expire     = 1'b1;
               state_next = GAP;
            end
         end
         GAP:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_reg <= '0;
         cnt_reg <= '0;
         gnt     <= '0;
         done    <= '0;
         err     <= '0;
         q_write <= 1'b0;
         q_mem   <= 1'b0;
         q_tag   <= '0;
         q_chan  <= '0;
      end else begin
         done <= '0;
         err  <= '0;
         if (start) begin
            gnt      <= '0;
            gnt[win] <= 1'b1;
            q_write  <= write[win];
            q_mem    <= mem[win];
            q_tag    <= tag_arr[win];
            q_chan   <= win;
            cnt_reg  <= '0;
         end
         if (state_reg == BUSY) begin
            cnt_reg <= cnt_reg + CW'(1);
         end
         if (finish_ok) begin
            done[q_chan] <= 1'b1;
            gnt          <= '0;
            ptr_reg      <= ptr_next;
         end
         if (expire) begin
            err[q_chan] <= 1'b1;
            gnt         <= '0;
            ptr_reg     <= ptr_next;
         end
      end
   end

endmodule

// File: tb/tb_line_arb.sv
// Scoreboard bench for line_arb: a round-robin 2-channel instance with a short
// watchdog and a fixed-priority 4-channel instance.
module tb_line_arb;

   localparam int TW = 20;

   typedef struct packed {
      logic [3:0]    gnt;
      logic [1:0]    chan;
      logic [TW-1:0] tag;
      logic          wr;
      logic          mm;
      logic          ok;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset;
   logic [1:0]      req, write, mem, gnt, done, err;
   logic [2*TW-1:0] tag;
   logic            q_req, q_write, q_mem, q_done;
   logic [TW-1:0]   q_tag;
   logic [0:0]      q_chan;

   logic [3:0]      req_fp, write_fp, mem_fp, gnt_fp, done_fp, err_fp;
   logic [4*TW-1:0] tag_fp;
   logic            q_req_fp, q_write_fp, q_mem_fp, q_done_fp;
   logic [TW-1:0]   q_tag_fp;
   logic [1:0]      q_chan_fp;

   line_arb #(.NCH(2), .PA(22), .LINE_LENGTH(4), .FIXED_PRIO(0), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .req(req), .write(write), .mem(mem), .tag(tag),
      .gnt(gnt), .done(done), .err(err), .q_req(q_req), .q_write(q_write),
      .q_mem(q_mem), .q_tag(q_tag), .q_chan(q_chan), .q_done(q_done)
   );

   line_arb #(.NCH(4), .PA(22), .LINE_LENGTH(4), .FIXED_PRIO(1), .TIMEOUT(255)) dut_fp (
      .clk(clk), .reset(reset), .req(req_fp), .write(write_fp), .mem(mem_fp), .tag(tag_fp),
      .gnt(gnt_fp), .done(done_fp), .err(err_fp), .q_req(q_req_fp), .q_write(q_write_fp),
      .q_mem(q_mem_fp), .q_tag(q_tag_fp), .q_chan(q_chan_fp), .q_done(q_done_fp)
   );

   int   n_vec = 0;
   int   n_bad = 0;
   int   n_grants = 0;
   exp_t rr_q[$];
   exp_t fp_q[$];
   exp_t cur;
   exp_t fp_cur;
   logic [1:0] gnt_prev;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push_rr(input logic [1:0] g, input logic [TW-1:0] t,
                          input logic wr, input logic mm, input logic ok);
      exp_t e;
      e.gnt  = {2'b00, g};
      e.chan = {1'b0, g[1]};
      e.tag  = t;
      e.wr   = wr;
      e.mm   = mm;
      e.ok   = ok;
      rr_q.push_back(e);
   endtask

   task automatic push_fp(input logic [1:0] ch);
      exp_t e;
      e.gnt  = 4'b0001 << ch;
      e.chan = ch;
      e.tag  = TW'(ch) * 20'h11111;
      e.wr   = 1'b0;
      e.mm   = 1'b0;
      e.ok   = 1'b1;
      fp_q.push_back(e);
   endtask

   // Scoreboard side for the round-robin instance.
   always @(negedge clk) begin
      if (reset) begin
         gnt_prev = 2'b00;
      end else begin
         if (gnt != 2'b00 && gnt_prev == 2'b00) begin
            n_grants++;
            if (rr_q.size() == 0) begin
               chk("rr_spurious_gnt", 64'(gnt), 64'd0);
            end else begin
               cur = rr_q.pop_front();
               $display("txn %0d: gnt=%b chan=%0d tag=%h write=%b mem=%b",
                        n_grants, gnt, q_chan, q_tag, q_write, q_mem);
               chk("rr_gnt", 64'(gnt), 64'(cur.gnt[1:0]));
               chk("rr_chan", 64'(q_chan), 64'(cur.chan[0]));
               chk("rr_tag", 64'(q_tag), 64'(cur.tag));
               chk("rr_write", 64'(q_write), 64'(cur.wr));
               chk("rr_mem", 64'(q_mem), 64'(cur.mm));
               chk("rr_q_req", 64'(q_req), 64'd1);
            end
         end
         if (done != 2'b00 || err != 2'b00) begin
            chk("rr_done_pulse", 64'(done), cur.ok ? 64'(cur.gnt[1:0]) : 64'd0);
            chk("rr_err_pulse", 64'(err), cur.ok ? 64'd0 : 64'(cur.gnt[1:0]));
         end
         gnt_prev = gnt;
      end
   end

   task automatic wait_grant(input int target);
      int k = 0;
      while (n_grants < target && k < 60) begin
         tick();
         k++;
      end
      if (n_grants < target) chk("rr_grant_wait", 64'(n_grants), 64'(target));
   endtask

   // Hold BUSY for 'cycles' more cycles, pulse q_done, then check GAP and the idle cycle.
   task automatic finish(input int cycles, input logic [1:0] exp_done);
      repeat (cycles) tick();
      q_done = 1'b1;
      tick();
      q_done = 1'b0;
      chk("gap_done", 64'(done), 64'(exp_done));
      chk("gap_err", 64'(err), 64'd0);
      chk("gap_q_req", 64'(q_req), 64'd0);
      chk("gap_gnt", 64'(gnt), 64'd0);
      tick();
      chk("idle_done", 64'(done), 64'd0);
   endtask

   task automatic fp_step();
      int k = 0;
      while (gnt_fp == 4'b0000 && k < 60) begin
         tick();
         k++;
      end
      if (fp_q.size() == 0) begin
         chk("fp_spurious_gnt", 64'(gnt_fp), 64'd0);
      end else begin
         fp_cur = fp_q.pop_front();
         $display("txn fp: gnt=%b chan=%0d tag=%h", gnt_fp, q_chan_fp, q_tag_fp);
         chk("fp_gnt", 64'(gnt_fp), 64'(fp_cur.gnt));
         chk("fp_chan", 64'(q_chan_fp), 64'(fp_cur.chan));
         chk("fp_tag", 64'(q_tag_fp), 64'(fp_cur.tag));
         chk("fp_q_req", 64'(q_req_fp), 64'd1);
      end
   endtask

   task automatic fp_finish();
      repeat (2) tick();
      q_done_fp = 1'b1;
      tick();
      q_done_fp = 1'b0;
      chk("fp_done", 64'(done_fp), 64'(fp_cur.gnt));
      chk("fp_gap_gnt", 64'(gnt_fp), 64'd0);
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int g;
      reset  = 1'b1;
      req    = '0; write = '0; mem = '0; tag = '0; q_done = 1'b0;
      req_fp = '0; write_fp = '0; mem_fp = '0; q_done_fp = 1'b0;
      tag_fp = {20'h33333, 20'h22222, 20'h11111, 20'h00000};
      repeat (3) tick();
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_q_req", 64'(q_req), 64'd0);
      chk("rst_q_tag", 64'(q_tag), 64'd0);
      chk("rst_q_chan", 64'(q_chan), 64'd0);
      chk("rst_q_write", 64'(q_write), 64'd0);
      chk("rst_q_mem", 64'(q_mem), 64'd0);
      chk("rst_fp_gnt", 64'(gnt_fp), 64'd0);
      reset = 1'b0;
      tick();

      // Fixed priority: 1110 grants channel 1, then 1111 keeps granting channel 0.
      req_fp = 4'b1110;
      push_fp(2'd1);
      fp_step();
      req_fp = 4'b1111;
      repeat (3) push_fp(2'd0);
      fp_finish();
      for (int i = 0; i < 3; i++) begin
         fp_step();
         if (i == 2) req_fp = 4'b0000;
         fp_finish();
      end

      // Single request with q_done in BUSY cycle 10.
      tag[TW-1:0] = 20'h12345; write = 2'b00; mem = 2'b01;
      push_rr(2'b01, 20'h12345, 1'b0, 1'b1, 1'b1);
      req = 2'b01;
      wait_grant(n_grants + 1);
      req = 2'b00;
      finish(9, 2'b01);

      // q_done while idle is ignored.
      q_done = 1'b1;
      tick();
      q_done = 1'b0;
      chk("idle_qdone_done", 64'(done), 64'd0);
      chk("idle_qdone_q_req", 64'(q_req), 64'd0);

      // Round-robin contention.
      do_reset();
      tag = {20'h55555, 20'hAAAAA}; write = 2'b10; mem = 2'b01;
      for (int i = 0; i < 2; i++) begin
         push_rr(2'b01, 20'hAAAAA, 1'b0, 1'b1, 1'b1);
         push_rr(2'b10, 20'h55555, 1'b1, 1'b0, 1'b1);
      end
      req = 2'b11;
      for (int i = 0; i < 4; i++) begin
         wait_grant(n_grants + 1);
         if (i == 3) req = 2'b00;
         finish(3, (i % 2 == 0) ? 2'b01 : 2'b10);
      end

      // Watchdog expiry, then the other requester is served.
      do_reset();
      push_rr(2'b01, 20'hAAAAA, 1'b0, 1'b1, 1'b0);
      push_rr(2'b10, 20'h55555, 1'b1, 1'b0, 1'b1);
      req = 2'b11;
      wait_grant(n_grants + 1);
      g = n_grants;
      for (int i = 1; i < 16; i++) begin
         tick();
         chk("wd_err_early", 64'(err), 64'd0);
      end
      tick();
      chk("wd_err", 64'(err), 64'd1);
      chk("wd_done", 64'(done), 64'd0);
      chk("wd_q_req", 64'(q_req), 64'd0);
      wait_grant(g + 1);
      req = 2'b00;
      finish(2, 2'b10);

      // Inputs change and req drops mid-BUSY.
      do_reset();
      tag[2*TW-1:TW] = 20'h0BEEF; write = 2'b10; mem = 2'b00;
      push_rr(2'b10, 20'h0BEEF, 1'b1, 1'b0, 1'b1);
      req = 2'b10;
      wait_grant(n_grants + 1);
      tag = {20'hFFFFF, 20'hFFFFF}; write = 2'b01; mem = 2'b11; req = 2'b00;
      repeat (2) tick();
      chk("hold_q_tag", 64'(q_tag), 64'h0BEEF);
      chk("hold_q_write", 64'(q_write), 64'd1);
      chk("hold_q_mem", 64'(q_mem), 64'd0);
      chk("hold_q_chan", 64'(q_chan), 64'd1);
      chk("hold_gnt", 64'(gnt), 64'd2);
      chk("hold_q_req", 64'(q_req), 64'd1);
      finish(1, 2'b10);

      // Reset in BUSY cycle 3 with ptr pointing at channel 1.
      tag = {20'h55555, 20'hAAAAA}; write = 2'b10; mem = 2'b01;
      push_rr(2'b01, 20'hAAAAA, 1'b0, 1'b1, 1'b1);
      req = 2'b01;
      wait_grant(n_grants + 1);
      req = 2'b00;
      finish(1, 2'b01);
      push_rr(2'b10, 20'h55555, 1'b1, 1'b0, 1'b1);
      req = 2'b10;
      wait_grant(n_grants + 1);
      repeat (2) tick();
      reset = 1'b1;
      tick();
      chk("mrst_gnt", 64'(gnt), 64'd0);
      chk("mrst_done", 64'(done), 64'd0);
      chk("mrst_err", 64'(err), 64'd0);
      chk("mrst_q_req", 64'(q_req), 64'd0);
      chk("mrst_q_tag", 64'(q_tag), 64'd0);
      chk("mrst_q_write", 64'(q_write), 64'd0);
      chk("mrst_q_chan", 64'(q_chan), 64'd0);
      reset = 1'b0;
      push_rr(2'b01, 20'hAAAAA, 1'b0, 1'b1, 1'b1);
      req = 2'b11;
      wait_grant(n_grants + 1);
      req = 2'b00;
      finish(2, 2'b01);

      chk("rr_queue_empty", 64'(rr_q.size()), 64'd0);
      chk("fp_queue_empty", 64'(fp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: got no finish, expected finish before 300000");
      $fatal(1, "bench timed out");
   end

endmodule
